// File: rtl/rib_rr_arbiter.sv
// rib_rr_arbiter: two-master round-robin RIB arbiter with ID FIFO routing in-order responses back
module rib_rr_arbiter #(
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_ribs0_addr,
  input  logic              i_ribs0_wrcs,
  input  logic [DATA_W/8-1:0] i_ribs0_mask,
  input  logic [DATA_W-1:0] i_ribs0_wdata,
  output logic [DATA_W-1:0] o_ribs0_rdata,
  input  logic              i_ribs0_req,
  output logic              o_ribs0_gnt,
  output logic              o_ribs0_rsp,
  input  logic              i_ribs0_rdy,
  input  logic [ADDR_W-1:0] i_ribs1_addr,
  input  logic              i_ribs1_wrcs,
  input  logic [DATA_W/8-1:0] i_ribs1_mask,
  input  logic [DATA_W-1:0] i_ribs1_wdata,
  output logic [DATA_W-1:0] o_ribs1_rdata,
  input  logic              i_ribs1_req,
  output logic              o_ribs1_gnt,
  output logic              o_ribs1_rsp,
  input  logic              i_ribs1_rdy,
  output logic [ADDR_W-1:0] o_ribm_addr,
  output logic              o_ribm_wrcs,
  output logic [DATA_W/8-1:0] o_ribm_mask,
  output logic [DATA_W-1:0] o_ribm_wdata,
  output logic              o_ribm_req,
  input  logic              i_ribm_gnt,
  input  logic [DATA_W-1:0] i_ribm_rdata,
  input  logic              i_ribm_rsp,
  output logic              o_ribm_rdy,
  output logic              o_err
);
  localparam int PW = $clog2(MAX_OUTST);
  localparam logic [PW:0] L_FULL = (PW+1)'(MAX_OUTST);
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_fifo [MAX_OUTST];
  logic          r_hold, r_held_id, r_last, r_err;
  logic          w_run, w_sel, w_req, w_push, w_pop, w_empty, w_head, w_rdy;
  // every combinational output is forced low while reset is applied
  assign w_run   = !i_rst;
  assign w_sel   = r_hold ? r_held_id : (i_ribs0_req & i_ribs1_req) ? ~r_last : i_ribs1_req;
  assign w_req   = w_run & (w_sel ? i_ribs1_req : i_ribs0_req) & (r_count != L_FULL);
  assign w_push  = w_req & i_ribm_gnt;
  assign w_empty = r_count == '0;
  assign w_head  = r_fifo[r_rd_ptr];
  assign w_rdy   = w_run & !w_empty & (w_head ? i_ribs1_rdy : i_ribs0_rdy);
  assign w_pop   = i_ribm_rsp & w_rdy;
  assign o_ribm_addr   = w_run ? (w_sel ? i_ribs1_addr : i_ribs0_addr) : '0;
  assign o_ribm_wrcs   = w_run & (w_sel ? i_ribs1_wrcs : i_ribs0_wrcs);
  assign o_ribm_mask   = w_run ? (w_sel ? i_ribs1_mask : i_ribs0_mask) : '0;
  assign o_ribm_wdata  = w_run ? (w_sel ? i_ribs1_wdata : i_ribs0_wdata) : '0;
  assign o_ribm_req    = w_req;
  assign o_ribm_rdy    = w_rdy;
  assign o_ribs0_gnt   = w_push & !w_sel;
  assign o_ribs1_gnt   = w_push & w_sel;
  assign o_ribs0_rsp   = w_run & i_ribm_rsp & !w_empty & !w_head;
  assign o_ribs1_rsp   = w_run & i_ribm_rsp & !w_empty & w_head;
  assign o_ribs0_rdata = w_run ? i_ribm_rdata : '0;
  assign o_ribs1_rdata = w_run ? i_ribm_rdata : '0;
  assign o_err         = r_err;
  always_ff @(posedge i_clk)
    if (w_push) r_fifo[r_wr_ptr] <= w_sel;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_hold    <= 1'b0;
      r_held_id <= 1'b0;
      r_last    <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_last   <= w_sel;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      // a stalled request pins the selection until the slave grants it
      if (w_push) r_hold <= 1'b0;
      else if (w_req) begin
        r_hold    <= 1'b1;
        r_held_id <= w_sel;
      end
      if (i_ribm_rsp & w_empty) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rib_rr_arbiter.sv
// tb_rib_rr_arbiter: directed scenarios plus randomized traffic against a queue-based reference model
module tb_rib_rr_arbiter;
  localparam int MAX = 4;
  logic clk = 0, rst = 1;
  logic [31:0] a0, a1, d0, d1, rdata;
  logic [3:0]  m0, m1;
  logic w0, w1, req0, req1, rdy0, rdy1, gnt, rsp;
  logic [31:0] rd0, rd1, maddr, mwdata;
  logic [3:0]  mmask;
  logic g0o, g1o, r0o, r1o, mwrcs, mreq, mrdy, err;
  int checks = 0, errors = 0;
  int q[$];
  int prio, pend;
  logic merr;

  rib_rr_arbiter #(.MAX_OUTST(MAX), .ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ribs0_addr(a0), .i_ribs0_wrcs(w0), .i_ribs0_mask(m0), .i_ribs0_wdata(d0),
    .o_ribs0_rdata(rd0), .i_ribs0_req(req0), .o_ribs0_gnt(g0o), .o_ribs0_rsp(r0o), .i_ribs0_rdy(rdy0),
    .i_ribs1_addr(a1), .i_ribs1_wrcs(w1), .i_ribs1_mask(m1), .i_ribs1_wdata(d1),
    .o_ribs1_rdata(rd1), .i_ribs1_req(req1), .o_ribs1_gnt(g1o), .o_ribs1_rsp(r1o), .i_ribs1_rdy(rdy1),
    .o_ribm_addr(maddr), .o_ribm_wrcs(mwrcs), .o_ribm_mask(mmask), .o_ribm_wdata(mwdata),
    .o_ribm_req(mreq), .i_ribm_gnt(gnt), .i_ribm_rdata(rdata), .i_ribm_rsp(rsp),
    .o_ribm_rdy(mrdy), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs;
    a0 = 0; a1 = 0; d0 = 0; d1 = 0; m0 = 0; m1 = 0; w0 = 0; w1 = 0;
    req0 = 0; req1 = 0; rdy0 = 0; rdy1 = 0; gnt = 0; rsp = 0; rdata = 0;
  endtask

  task automatic do_reset;
    clr_inputs;
    rst = 1;
    tick;
    tick;
    rst = 0;
  endtask

  task automatic test_reset;
    clr_inputs;
    rst = 0;
    tick;
    req0 = 1; req1 = 1; gnt = 1; rsp = 1; rdy0 = 1; rdy1 = 1;
    a0 = 32'h55; a1 = 32'h66; d0 = 32'h77; m0 = 4'hF; w0 = 1; rdata = 32'h1234;
    #1 rst = 1;
    #1;
    checks++;
    if ({mreq, g0o, g1o, r0o, r1o, mrdy, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000", {mreq, g0o, g1o, r0o, r1o, mrdy, err});
    end
    checks++;
    if ({maddr, mwdata, mmask, mwrcs, rd0, rd1} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %0h wdata %0h mask %0h rdata0 %0h want all 0", maddr, mwdata, mmask, rd0);
    end
    do_reset;
  endtask

  task automatic test_single_read;
    req0 = 1; a0 = 32'h100; w0 = 0; gnt = 1;
    #3;
    checks++;
    if ({maddr, g0o, g1o, mreq} !== {32'h100, 3'b101}) begin
      errors++;
      $display("FAIL single_cmd: addr %0h gnt0 %b gnt1 %b req %b want 100 1 0 1", maddr, g0o, g1o, mreq);
    end
    tick;
    req0 = 0; gnt = 0; rsp = 1; rdata = 32'hDEADBEEF; rdy0 = 1;
    #3;
    checks++;
    if ({r0o, r1o, mrdy, rd0} !== {3'b101, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_rsp: rsp0 %b rsp1 %b rdy %b rdata %0h want 1 0 1 deadbeef", r0o, r1o, mrdy, rd0);
    end
    tick;
    rsp = 0;
    #3;
    checks++;
    if (mrdy !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: ribm_rdy %b want 0", mrdy);
    end
    do_reset;
  endtask

  task automatic test_round_robin;
    req0 = 1; req1 = 1; gnt = 1; rdy0 = 1; rdy1 = 1;
    for (int i = 0; i < 4; i++) begin
      rsp = (i > 0);
      #3;
      checks++;
      if ({g0o, g1o} !== {i % 2 == 0, i % 2 == 1}) begin
        errors++;
        $display("FAIL rr_gnt%0d: gnt0 %b gnt1 %b want %b %b", i, g0o, g1o, i % 2 == 0, i % 2 == 1);
      end
      if (i > 0) begin
        checks++;
        if ({r0o, r1o} !== {(i - 1) % 2 == 0, (i - 1) % 2 == 1}) begin
          errors++;
          $display("FAIL rr_rsp%0d: rsp0 %b rsp1 %b want %b %b", i, r0o, r1o, (i - 1) % 2 == 0, (i - 1) % 2 == 1);
        end
      end
      tick;
    end
    do_reset;
  endtask

  task automatic test_stall;
    req0 = 1; req1 = 1; a0 = 32'hA0; a1 = 32'hB1; gnt = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++;
      if ({maddr, g1o, mreq} !== {32'hA0, 2'b01}) begin
        errors++;
        $display("FAIL stall%0d: addr %0h gnt1 %b req %b want a0 0 1", i, maddr, g1o, mreq);
      end
      tick;
    end
    gnt = 1;
    #3;
    checks++;
    if ({g0o, g1o} !== 2'b10) begin
      errors++;
      $display("FAIL stall_gnt0: gnt0 %b gnt1 %b want 1 0", g0o, g1o);
    end
    tick;
    #3;
    checks++;
    if ({maddr, g0o, g1o} !== {32'hB1, 2'b01}) begin
      errors++;
      $display("FAIL stall_gnt1: addr %0h gnt0 %b gnt1 %b want b1 0 1", maddr, g0o, g1o);
    end
    tick;
    // last winner is M1; grant M0 so an unpinned tie would now pick M1
    req1 = 0; a0 = 32'hC0;
    tick;
    gnt = 0;
    tick;
    req1 = 1;
    #3;
    checks++;
    if ({maddr, g1o} !== {32'hC0, 1'b0}) begin
      errors++;
      $display("FAIL hold_pin: addr %0h gnt1 %b want c0 0", maddr, g1o);
    end
    do_reset;
  endtask

  task automatic test_full;
    req0 = 1; gnt = 1;
    for (int i = 0; i < 4; i++) begin
      #3;
      checks++;
      if (g0o !== 1'b1) begin
        errors++;
        $display("FAIL full_gnt%0d: gnt0 %b want 1", i, g0o);
      end
      tick;
    end
    #3;
    checks++;
    if ({mreq, g0o} !== 2'b00) begin
      errors++;
      $display("FAIL full_block: req %b gnt0 %b want 0 0", mreq, g0o);
    end
    tick;
    rsp = 1; rdy0 = 1;
    #3;
    checks++;
    if ({mreq, r0o} !== 2'b01) begin
      errors++;
      $display("FAIL full_pop_cycle: req %b rsp0 %b want 0 1", mreq, r0o);
    end
    tick;
    rsp = 0;
    #3;
    checks++;
    if ({mreq, g0o} !== 2'b11) begin
      errors++;
      $display("FAIL full_unblock: req %b gnt0 %b want 1 1", mreq, g0o);
    end
    do_reset;
  endtask

  task automatic test_resp_order;
    req1 = 1; gnt = 1;
    tick;
    req1 = 0; req0 = 1;
    #3;
    checks++;
    if (g0o !== 1'b1) begin
      errors++;
      $display("FAIL order_gnt0: gnt0 %b want 1", g0o);
    end
    tick;
    req0 = 0; gnt = 0; rsp = 1; rdy0 = 1; rdy1 = 0; rdata = 32'h11;
    for (int i = 0; i < 2; i++) begin
      #3;
      checks++;
      if ({mrdy, r0o, r1o} !== 3'b001) begin
        errors++;
        $display("FAIL order_stall%0d: rdy %b rsp0 %b rsp1 %b want 0 0 1", i, mrdy, r0o, r1o);
      end
      tick;
    end
    rdy1 = 1;
    #3;
    checks++;
    if ({mrdy, r0o, r1o} !== 3'b101) begin
      errors++;
      $display("FAIL order_first: rdy %b rsp0 %b rsp1 %b want 1 0 1", mrdy, r0o, r1o);
    end
    tick;
    rdata = 32'h22;
    #3;
    checks++;
    if ({mrdy, r0o, r1o, rd0} !== {3'b110, 32'h22}) begin
      errors++;
      $display("FAIL order_second: rdy %b rsp0 %b rsp1 %b rdata %0h want 1 1 0 22", mrdy, r0o, r1o, rd0);
    end
    do_reset;
  endtask

  task automatic test_err_reset;
    rsp = 1; rdy0 = 1; rdy1 = 1;
    #3;
    checks++;
    if ({r0o, r1o, mrdy} !== 3'b000) begin
      errors++;
      $display("FAIL err_rsp: rsp0 %b rsp1 %b rdy %b want 0 0 0", r0o, r1o, mrdy);
    end
    tick;
    rsp = 0;
    tick;
    tick;
    #3;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err %b want 1", err);
    end
    req0 = 1; req1 = 1; gnt = 1;
    tick;
    tick;
    rsp = 1;
    #1 rst = 1;
    #1;
    checks++;
    if ({g0o, g1o, r0o, r1o, mreq, mrdy, err} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset: got %b want 0000000", {g0o, g1o, r0o, r1o, mreq, mrdy, err});
    end
    tick;
    rst = 0;
    clr_inputs;
    rdy0 = 1; rdy1 = 1;
    #3;
    checks++;
    if (mrdy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_empty: ribm_rdy %b want 0", mrdy);
    end
    do_reset;
  endtask

  task automatic test_random;
    int s, head;
    logic emreq, eg, erdy, gp0, gp1;
    logic [6:0] ev;
    q.delete();
    prio = 0; pend = -1; merr = 0; gp0 = 0; gp1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!req0 || gp0) begin
        req0 = 1'($urandom); a0 = $urandom; d0 = $urandom; m0 = 4'($urandom); w0 = 1'($urandom);
      end
      if (!req1 || gp1) begin
        req1 = 1'($urandom); a1 = $urandom; d1 = $urandom; m1 = 4'($urandom); w1 = 1'($urandom);
      end
      gnt = ($urandom % 4) != 0;
      rsp = ($urandom % 3) == 0;
      rdy0 = ($urandom % 4) != 0;
      rdy1 = ($urandom % 4) != 0;
      rdata = $urandom;
      s = pend >= 0 ? pend : (req0 && req1) ? prio : (req1 ? 1 : 0);
      emreq = (s == 1 ? req1 : req0) && q.size() < MAX;
      eg = gnt && emreq;
      head = q.size() > 0 ? q[0] : -1;
      erdy = head >= 0 && (head == 1 ? rdy1 : rdy0);
      ev = {emreq, eg && s == 0, eg && s == 1, rsp && head == 0, rsp && head == 1, erdy, merr};
      #3;
      checks++;
      if ({mreq, g0o, g1o, r0o, r1o, mrdy, err} !== ev) begin
        errors++;
        $display("FAIL rand_ctrl@%0d: got %b want %b", c, {mreq, g0o, g1o, r0o, r1o, mrdy, err}, ev);
      end
      checks++;
      if ({maddr, mwdata, mmask, mwrcs, rd1} !== (s == 1 ? {a1, d1, m1, w1, rdata} : {a0, d0, m0, w0, rdata})) begin
        errors++;
        $display("FAIL rand_data@%0d: addr %0h wdata %0h rdata1 %0h sel %0d", c, maddr, mwdata, rd1, s);
      end
      if (rsp && head < 0) merr = 1;
      if (eg) begin
        q.push_back(s);
        prio = 1 - s;
        pend = -1;
      end else if (emreq) pend = s;
      if (rsp && erdy) void'(q.pop_front());
      gp0 = eg && s == 0;
      gp1 = eg && s == 1;
      tick;
    end
    do_reset;
  endtask

  initial begin
    clr_inputs;
    test_reset;
    test_single_read;
    test_round_robin;
    test_stall;
    test_full;
    test_resp_order;
    test_err_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
